// File: rtl/core_pkg.sv
// core_pkg: shared arbiter state, requester id and latency limit
package core_pkg;
    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
    typedef enum logic {REQ_IF, REQ_D} req_id_t;
    localparam int MEM_LATENCY_MAX = 7;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick, the requester that did not win last takes a tie
module rr_arbiter2
    import core_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    input  logic       en,
    output logic [1:0] gnt
);
    always_comb begin
        gnt[0] = en && req[0] && (!req[1] || last == REQ_D);
        gnt[1] = en && req[1] && (!req[0] || last == REQ_IF);
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store, one access in flight
module mem_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int CNT_W = $clog2(MEM_LATENCY_MAX + 1);
    arb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    req_id_t          r_owner;
    req_id_t          r_last;
    logic             r_we;
    logic             w_win;
    logic             w_resp;
    logic [1:0]       w_gnt;
    assign w_win  = !reset && (r_state == ARB_IDLE || r_cnt == '0);
    assign w_resp = !reset && r_state == ARB_BUSY && r_cnt == '0;
    rr_arbiter2 u_rr (
        .req  ({d_req, if_req}),
        .last (r_last),
        .en   (w_win),
        .gnt  (w_gnt)
    );
    always_comb begin
        if_gnt    = w_gnt[0];
        d_gnt     = w_gnt[1];
        mem_en    = |w_gnt;
        mem_we    = w_gnt[1] && d_we;
        mem_be    = w_gnt[1] ? d_be : w_gnt[0] ? '1 : '0;
        mem_addr  = w_gnt[1] ? d_addr : w_gnt[0] ? if_addr : '0;
        mem_wdata = w_gnt[1] ? d_wdata : '0;
        if_rvalid = w_resp && r_owner == REQ_IF;
        d_rvalid  = w_resp && r_owner == REQ_D;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = (d_rvalid && !r_we) ? mem_rdata : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_cnt   <= '0;
            r_owner <= REQ_IF;
            r_we    <= 1'b0;
            r_last  <= REQ_D;
        end else if (mem_en) begin
            r_state <= ARB_BUSY;
            r_cnt   <= CNT_W'(MEM_LATENCY - 1);
            r_owner <= w_gnt[1] ? REQ_D : REQ_IF;
            r_we    <= mem_we;
            r_last  <= w_gnt[1] ? REQ_D : REQ_IF;
        end else if (r_state == ARB_BUSY) begin
            r_state <= (r_cnt == '0) ? ARB_IDLE : ARB_BUSY;
            r_cnt   <= (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for latency-1 and latency-3 arbiters sharing one stimulus
module tb_mem_arbiter;
    typedef logic [159:0] v_t;
    typedef struct {
        int          c;
        logic        d;
        logic [31:0] a;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
    } g_t;
    typedef struct {
        int          c;
        logic        d;
        logic [31:0] data;
    } r_t;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        if_req = 1'b0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] if_addr = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] mem_rdata;
    logic [31:0] pipe [8];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    g_t          gq [$];
    r_t          rq [$];
    logic [1:0]  a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we;
    logic [31:0] a_if_rdata [2];
    logic [31:0] a_d_rdata [2];
    logic [31:0] a_mem_addr [2];
    logic [31:0] a_mem_wdata [2];
    logic [3:0]  a_mem_be [2];
    logic        m_if_gnt, m_if_rvalid, m_d_gnt, m_d_rvalid, m_mem_en, m_mem_we;
    logic [31:0] m_if_rdata, m_d_rdata, m_mem_addr, m_mem_wdata;
    logic [3:0]  m_mem_be;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(g == 0 ? 1 : 3)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .if_req    (if_req && sel == 1'(g)),
            .if_addr   (if_addr),
            .if_gnt    (a_if_gnt[g]),
            .if_rvalid (a_if_rvalid[g]),
            .if_rdata  (a_if_rdata[g]),
            .d_req     (d_req && sel == 1'(g)),
            .d_we      (d_we),
            .d_be      (d_be),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_gnt     (a_d_gnt[g]),
            .d_rvalid  (a_d_rvalid[g]),
            .d_rdata   (a_d_rdata[g]),
            .mem_en    (a_mem_en[g]),
            .mem_we    (a_mem_we[g]),
            .mem_be    (a_mem_be[g]),
            .mem_addr  (a_mem_addr[g]),
            .mem_wdata (a_mem_wdata[g]),
            .mem_rdata (mem_rdata)
        );
    end
    assign m_if_gnt    = a_if_gnt[sel];
    assign m_if_rvalid = a_if_rvalid[sel];
    assign m_if_rdata  = a_if_rdata[sel];
    assign m_d_gnt     = a_d_gnt[sel];
    assign m_d_rvalid  = a_d_rvalid[sel];
    assign m_d_rdata   = a_d_rdata[sel];
    assign m_mem_en    = a_mem_en[sel];
    assign m_mem_we    = a_mem_we[sel];
    assign m_mem_be    = a_mem_be[sel];
    assign m_mem_addr  = a_mem_addr[sel];
    assign m_mem_wdata = a_mem_wdata[sel];
    // memory returns addr+3, delayed by the selected instance's latency
    always @(posedge clk) begin
        pipe[0] <= m_mem_addr;
        for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
        cyc <= cyc + 1;
    end
    assign mem_rdata = (sel ? pipe[2] : pipe[0]) + 32'd3;
    task automatic chk(string n, v_t a, v_t e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic set_if(logic r, logic [31:0] a);
        if_req  = r;
        if_addr = a;
    endtask
    task automatic set_d(logic r, logic we, logic [3:0] be, logic [31:0] a, logic [31:0] wd);
        d_req   = r;
        d_we    = we;
        d_be    = be;
        d_addr  = a;
        d_wdata = wd;
    endtask
    task automatic exp_g(int c, logic d, logic [31:0] a, logic we, logic [3:0] be, logic [31:0] wd);
        gq.push_back('{c, d, a, we, be, wd});
    endtask
    task automatic exp_r(int c, logic d, logic [31:0] data);
        rq.push_back('{c, d, data});
    endtask
    function automatic v_t outs();
        return v_t'({m_if_gnt, m_if_rvalid, m_if_rdata, m_d_gnt, m_d_rvalid, m_d_rdata,
                     m_mem_en, m_mem_we, m_mem_be, m_mem_addr, m_mem_wdata});
    endfunction
    task automatic do_reset();
        reset = 1'b1;
        set_if(0, 0);
        set_d(0, 0, 0, 0, 0);
        tick(1);
        @(negedge clk);
        chk("reset_out", outs(), '0);
        tick(1);
        reset = 1'b0;
    endtask
    always @(negedge clk) begin
        g_t g;
        r_t r;
        if (m_mem_en) begin
            if (gq.size() == 0) chk("grant_unexpected", v_t'({cyc, m_d_gnt, m_if_gnt, m_mem_addr}), '0);
            else begin
                g = gq.pop_front();
                chk("grant", v_t'({cyc, m_d_gnt, m_if_gnt, m_mem_addr, m_mem_we, m_mem_be, m_mem_wdata}),
                    v_t'({g.c, g.d, !g.d, g.a, g.we, g.be, g.wd}));
            end
        end else begin
            chk("idle_mem", v_t'({m_if_gnt, m_d_gnt, m_mem_we, m_mem_be, m_mem_addr, m_mem_wdata}), '0);
        end
        if (m_if_rvalid || m_d_rvalid) begin
            if (rq.size() == 0) chk("rsp_unexpected", v_t'({cyc, m_d_rvalid, m_if_rvalid}), '0);
            else begin
                r = rq.pop_front();
                chk("rsp", v_t'({cyc, m_d_rvalid, m_if_rvalid, m_if_rdata, m_d_rdata}),
                    v_t'({r.c, r.d, !r.d, r.d ? 32'd0 : r.data, r.d ? r.data : 32'd0}));
            end
        end else begin
            chk("idle_rsp", v_t'({m_if_rdata, m_d_rdata}), '0);
        end
    end
    initial begin
        int t;
        do_reset();
        t = cyc;
        set_if(1, 32'h10);
        exp_g(t, 0, 32'h10, 0, 4'hF, 0);
        exp_r(t + 1, 0, 32'h13);
        tick(1);
        set_if(0, 0);
        tick(2);
        do_reset();
        t = cyc;
        set_if(1, 32'h20);
        set_d(1, 0, 4'hF, 32'h200, 0);
        exp_g(t, 0, 32'h20, 0, 4'hF, 0);
        exp_r(t + 1, 0, 32'h23);
        exp_g(t + 1, 1, 32'h200, 0, 4'hF, 0);
        exp_r(t + 2, 1, 32'h203);
        tick(1);
        set_if(0, 0);
        tick(1);
        set_d(0, 0, 0, 0, 0);
        tick(2);
        t = cyc;
        set_d(1, 1, 4'b0011, 32'h100, 32'hDEADBEEF);
        exp_g(t, 1, 32'h100, 1, 4'b0011, 32'hDEADBEEF);
        exp_r(t + 1, 1, 0);
        tick(1);
        set_d(0, 0, 0, 0, 0);
        tick(2);
        sel = 1'b1;
        do_reset();
        t = cyc;
        set_if(1, 32'h40);
        set_d(1, 0, 4'hF, 32'h400, 0);
        for (int k = 0; k < 4; k++) begin
            exp_g(t + 3 * k, k[0], k[0] ? 32'h400 : 32'h40, 0, 4'hF, 0);
            exp_r(t + 3 * k + 3, k[0], k[0] ? 32'h403 : 32'h43);
        end
        tick(12);
        set_if(0, 0);
        set_d(0, 0, 0, 0, 0);
        tick(4);
        t = cyc;
        set_d(1, 0, 4'hF, 32'h300, 0);
        exp_g(t, 1, 32'h300, 0, 4'hF, 0);
        tick(1);
        reset = 1'b1;
        set_if(1, 32'h50);
        set_d(1, 0, 4'hF, 32'h500, 0);
        tick(1);
        @(negedge clk);
        chk("reset_busy_out", outs(), '0);
        tick(1);
        reset = 1'b0;
        t = cyc;
        exp_g(t, 0, 32'h50, 0, 4'hF, 0);
        exp_r(t + 3, 0, 32'h53);
        tick(1);
        set_if(0, 0);
        set_d(0, 0, 0, 0, 0);
        tick(5);
        sel = 1'b0;
        t = cyc;
        set_if(1, 32'h60);
        set_d(1, 0, 4'hC, 32'h602, 0);
        exp_g(t, 0, 32'h60, 0, 4'hF, 0);
        exp_r(t + 1, 0, 32'h63);
        exp_g(t + 1, 1, 32'h602, 0, 4'hC, 0);
        exp_r(t + 2, 1, 32'h605);
        exp_g(t + 2, 0, 32'h64, 0, 4'hF, 0);
        exp_r(t + 3, 0, 32'h67);
        tick(1);
        set_if(1, 32'h64);
        tick(1);
        set_d(0, 0, 0, 0, 0);
        tick(1);
        set_if(0, 0);
        tick(3);
        chk("grants_left", v_t'(gq.size()), '0);
        chk("rsps_left", v_t'(rq.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
